// File: rtl/icache_fill_responder_if.sv
// Fetch-side miss request/response bundle for icache_fill_responder.
// The fetch stage drives it through the master modport; the responder uses the slave modport.
interface icache_fill_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int TID_WIDTH  = 2,
    parameter int LINE_WIDTH = 128
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [TID_WIDTH-1:0]  req_thread_id;
    logic                  rsp_valid_miss;
    logic [TID_WIDTH-1:0]  rsp_thread_id;
    logic [LINE_WIDTH-1:0] rsp_data_miss;
    logic                  rsp_bus_error;

    modport master (
        output req_valid, req_addr, req_thread_id,
        input  req_ready, rsp_valid_miss, rsp_thread_id, rsp_data_miss, rsp_bus_error
    );

    modport slave (
        input  req_valid, req_addr, req_thread_id,
        output req_ready, rsp_valid_miss, rsp_thread_id, rsp_data_miss, rsp_bus_error
    );
endinterface

// File: rtl/icache_fill_responder.sv
// In-order instruction-cache line-fill responder with a fixed memory latency and preloadable array.
// Optional macro ICACHE_FILL_BUS_ERROR_EN flags out-of-range line indices instead of wrapping them.
module icache_fill_responder #(
    parameter int THR_PER_CORE       = 4,
    parameter int THR_PER_CORE_WIDTH = 2,
    parameter int ICACHE_LINE_WIDTH  = 128,
    parameter int PHY_ADDR_RANGE     = 32,
    parameter int LATENCY            = 10,
    parameter int DEPTH              = THR_PER_CORE,
    parameter int MEM_LINES          = 1024,
    parameter int LINE_WIDTH         = ICACHE_LINE_WIDTH
) (
    input  logic                          clock,
    input  logic                          reset,
    icache_fill_responder_if.slave        bus,
    input  logic                          mem_wr_en,
    input  logic [$clog2(MEM_LINES)-1:0]  mem_wr_line,
    input  logic [LINE_WIDTH-1:0]         mem_wr_data
);
    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    localparam int IDX_BITS    = $clog2(MEM_LINES);
    localparam int PTR_BITS    = $clog2(DEPTH);
`ifdef ICACHE_FILL_BUS_ERROR_EN
    localparam int LIDX_W      = PHY_ADDR_RANGE - OFFSET_BITS;
`else
    localparam int LIDX_W      = IDX_BITS;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                          state, next_state;
    logic [LIDX_W-1:0]               fifo_line [DEPTH];
    logic [THR_PER_CORE_WIDTH-1:0]   fifo_tid  [DEPTH];
    logic [PTR_BITS-1:0]             wr_ptr, rd_ptr;
    logic [PTR_BITS:0]               count;
    logic                            full, empty, push, pop, latch;
    logic [7:0]                      cnt;
    logic [LIDX_W-1:0]               cur_line;
    logic [LINE_WIDTH-1:0]           mem [MEM_LINES];
    logic [LINE_WIDTH-1:0]           read_data;
    logic                            oob;
    logic                            rsp_valid_q, rsp_err_q;
    logic [THR_PER_CORE_WIDTH-1:0]   rsp_tid_q;
    logic [LINE_WIDTH-1:0]           rsp_data_q;

    assign full          = (count == (PTR_BITS+1)'(DEPTH));
    assign empty         = (count == '0);
    assign push          = bus.req_valid & ~full;
    assign bus.req_ready = ~full;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Only the line index is kept; byte-offset bits never influence the fill.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_line[wr_ptr] <= bus.req_addr[OFFSET_BITS +: LIDX_W];
            fifo_tid[wr_ptr]  <= bus.req_thread_id;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_wr_en)
            mem[mem_wr_line] <= mem_wr_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        latch      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 8'd0) begin
                    latch      = 1'b1;
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

`ifdef ICACHE_FILL_BUS_ERROR_EN
    assign oob       = |(cur_line >> IDX_BITS);
    assign read_data = oob ? '0 : mem[cur_line[IDX_BITS-1:0]];
`else
    assign oob       = 1'b0;
    assign read_data = mem[cur_line[IDX_BITS-1:0]];
`endif

    // The array read happens in the same edge as any preload write, so a collision returns old data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            cur_line    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_tid_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= latch;
            if (pop) begin
                cnt       <= 8'(LATENCY - 1);
                cur_line  <= fifo_line[rd_ptr];
                rsp_tid_q <= fifo_tid[rd_ptr];
            end else if (state == WAIT && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            if (latch) begin
                rsp_data_q <= read_data;
                rsp_err_q  <= oob;
            end
        end
    end

    assign bus.rsp_valid_miss = rsp_valid_q;
    assign bus.rsp_thread_id  = rsp_tid_q;
    assign bus.rsp_data_miss  = rsp_data_q;
    assign bus.rsp_bus_error  = rsp_err_q;
endmodule
